retire_trace_buffer: RTL
========================

# retire_trace_buffer

Testbench-side capture stage that consumes the per-retirement trace signals tapped from the core (valid, pc, inst, writeback, exception, privilege, hartid) and buffers them as packed records in a FIFO. It sits directly downstream of the core trace tap and upstream of the trace logger / reference-model comparator, which drains records over a valid/ready handshake. Every retirement gets a sequence number, so the consumer can detect records dropped on overflow.

## Interface
- DEPTH, 16: FIFO entries; power of 2, ≥2
- DROP_W, 16: width of the saturating drop counter
- clock  in  1  sole clock; all state on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  instruction retired this cycle
- in_excpt  in  1  retirement took an exception
- in_priv_mode  in  3  privilege mode
- in_hartid  in  32  hart id
- in_pc  in  32  retired PC
- in_inst  in  32  instruction word
- in_wrdst  in  5  destination register
- in_wrdata  in  32  writeback data
- in_wrenx  in  1  integer RF write
- in_wrenf  in  1  FP RF write
- out_valid  out  1  head record available
- out_ready  in  1  consumer accepts head
- out_rec  out  retire_rec_t  head record (seq, gap, excpt, priv, hartid, pc, inst, wrdst, wrdata, wrenx, wrenf, cycle)
- drop_count  out  DROP_W  records dropped since reset, saturating
- overflow  out  1  sticky: at least one drop since reset
- level  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Push condition: in_valid && (!full || pop), where pop = out_valid && out_ready.
- Record fields are captured from the inputs in the push cycle. When in_excpt=1: wrenx, wrenf, wrdst and wrdata are stored as 0. When wrenx=wrenf=0: wrdata and wrdst are stored as 0.
- seq: 32-bit counter, incremented on every in_valid, including dropped ones. The first retirement after reset has seq=0. Wraps from 0xFFFFFFFF to 0.
- Drop: in_valid && full && !pop → record discarded; drop_count += 1, saturating at all-ones; overflow ← 1; gap_pending ← 1.
- gap: stored as gap_pending on the next successful push, which then clears gap_pending. If the drop and the push occur in the same cycle, the cycle's record is the drop, so gap_pending stays set.
- Pop: on out_valid && out_ready, the head advances. Push and pop are allowed in the same cycle at any occupancy, including full.
- out_rec is held stable while out_valid && !out_ready.
- Pointers: log2(DEPTH) bits plus a wrap bit. full = (level == DEPTH), empty = (level == 0).

## Timing
- Push at cycle N → record visible at out_rec with out_valid=1 in cycle N+1 if the FIFO was empty. There is no combinational in→out path.
- out_valid is registered-state derived (!empty). out_ready does not combinationally affect out_valid.
- Reset (any cycle, including mid-drain): pointers=0, level=0, out_valid=0, out_rec=0, seq=0, drop_count=0, overflow=0, gap_pending=0, cycle=0. Inputs asserted during reset are ignored.
- First push accepted is the cycle after reset deasserts.

## Configuration
- RETIRE_TRACE_TIMESTAMP_EN defined: a 32-bit free-running cycle counter runs from 0 after reset, wrapping. out_rec.cycle = counter value in the push cycle.
- Not defined: the counter is not instantiated and out_rec.cycle is constant 0. Record layout is unchanged, so consumers need no rebuild.

## Structure
- retire_trace_pkg holds:
  - typedef retire_rec_t (struct packed)
  - localparams for field widths (XLEN=32, REG_W=5, PRIV_W=3)
- Sub-module retire_trace_fifo: generic DEPTH×retire_rec_t synchronous FIFO with push/pop/full/empty/level.
- The top holds the seq counter, drop counter, gap_pending, record packing/masking and the timestamp.

## Test plan
- Single retire after reset (pc=0x8000_0000, inst=0x0000_0013, wrenx=1, wrdst=5, wrdata=0xDEAD_BEEF), out_ready=1 → next cycle out_valid=1, seq=0, gap=0, fields match; following cycle out_valid=0.
- Retirement with in_excpt=1, wrenx=1, wrdata=0x1234 → record shows excpt=1, wrenx=0, wrdst=0, wrdata=0.
- out_ready=0, DEPTH=16, 20 consecutive retires → level=16, drop_count=4, overflow=1. Then drain and push one more → drained seq 0..15 with gap=0; new record seq=20, gap=1.
- Full FIFO, in_valid=1 and out_ready=1 in the same cycle → no drop, level stays 16, drop_count unchanged.
- Reset asserted mid-drain with level=7 → next cycle out_valid=0, level=0, drop_count=0. First post-reset retire has seq=0.
- With RETIRE_TRACE_TIMESTAMP_EN, retires at cycles 3 and 10 after reset release → cycle fields 3 and 10. Without the macro → both 0.

Source files
------------

// File: rtl/retire_trace_pkg.sv
// ---------------------------------------------------------------------------
// retire_trace_pkg
// Shared types and field widths for the retirement trace capture path.
//   retire_rec_t : one packed retirement record as seen by the trace consumer.
//   REC_W        : total record width in bits.
// The record layout is identical whether or not RETIRE_TRACE_TIMESTAMP_EN is
// defined; with the macro undefined the cycle field is simply always zero.
// ---------------------------------------------------------------------------
package retire_trace_pkg;

  localparam int XLEN   = 32;
  localparam int REG_W  = 5;
  localparam int PRIV_W = 3;
  localparam int SEQ_W  = 32;
  localparam int CYC_W  = 32;

  typedef struct packed {
    logic [SEQ_W-1:0]  seq;     // retirement sequence number, counts drops too
    logic              gap;     // one or more records were dropped before this one
    logic              excpt;
    logic [PRIV_W-1:0] priv;
    logic [XLEN-1:0]   hartid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   inst;
    logic [REG_W-1:0]  wrdst;
    logic [XLEN-1:0]   wrdata;
    logic              wrenx;
    logic              wrenf;
    logic [CYC_W-1:0]  cycle;   // timestamp of the push cycle, or 0
  } retire_rec_t;

  localparam int REC_W = $bits(retire_rec_t);

endpackage

// File: rtl/retire_trace_fifo.sv
// ---------------------------------------------------------------------------
// retire_trace_fifo
// Synchronous DEPTH x retire_rec_t FIFO. Pointers carry one extra wrap bit so
// occupancy is simply wr_ptr - rd_ptr.
// Ports:
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   i_push, i_data    : write i_data at the tail (caller guarantees room,
//                       a push on a full FIFO is legal only with i_pop)
//   i_pop             : advance the head (caller guarantees !o_empty)
//   o_data            : head record, forced to 0 while empty
//   o_full, o_empty   : occupancy flags
//   o_level           : occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module retire_trace_fifo
  import retire_trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_push,
  input  retire_rec_t              i_data,
  input  logic                     i_pop,
  output retire_rec_t              o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  retire_rec_t   r_mem [DEPTH];
  logic [LW-1:0] r_wr_ptr;
  logic [LW-1:0] r_rd_ptr;
  logic [LW-1:0] w_level;

  assign w_level = r_wr_ptr - r_rd_ptr;
  assign o_level = w_level;
  assign o_full  = (w_level == LW'(DEPTH));
  assign o_empty = (w_level == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + LW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + LW'(1);
    end
  end

  // Storage needs no reset: nothing is visible until a pointer moves.
  always_ff @(posedge clock) begin
    if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  // Gated to zero when empty so the output is all-zero straight out of reset.
  assign o_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/retire_trace_buffer.sv
// ---------------------------------------------------------------------------
// retire_trace_buffer
// Captures one record per core retirement into a FIFO that the trace logger
// drains. Each retirement gets a sequence number; overflow drops are counted
// and the next stored record is flagged with gap=1.
// Optional feature macro: RETIRE_TRACE_TIMESTAMP_EN -- when defined, a 32-bit
// free-running cycle counter stamps each record; otherwise cycle is 0.
// Ports:
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   in_valid .. in_wrenf  : retirement trace tap from the core
//   out_valid, out_ready  : head record handshake to the consumer
//   out_rec               : head record
//   drop_count            : saturating count of discarded retirements
//   overflow              : sticky, set on the first drop
//   level                 : FIFO occupancy
// Handshake: a record transfers in any cycle where out_valid && out_ready.
// out_valid depends only on registered state (never on out_ready), and out_rec
// holds steady while out_valid && !out_ready.
// ---------------------------------------------------------------------------
module retire_trace_buffer
  import retire_trace_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic                   in_excpt,
  input  logic [PRIV_W-1:0]      in_priv_mode,
  input  logic [XLEN-1:0]        in_hartid,
  input  logic [XLEN-1:0]        in_pc,
  input  logic [XLEN-1:0]        in_inst,
  input  logic [REG_W-1:0]       in_wrdst,
  input  logic [XLEN-1:0]        in_wrdata,
  input  logic                   in_wrenx,
  input  logic                   in_wrenf,
  output logic                   out_valid,
  input  logic                   out_ready,
  output retire_rec_t            out_rec,
  output logic [DROP_W-1:0]      drop_count,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level
);

  logic [SEQ_W-1:0]  r_seq;
  logic [DROP_W-1:0] r_drop_count;
  logic              r_overflow;
  logic              r_gap_pending;

  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic              w_wb_live;
  logic [CYC_W-1:0]  w_cycle;
  retire_rec_t       w_rec;

  // A full FIFO still accepts when the head leaves in the same cycle.
  assign w_pop  = !w_empty && out_ready;
  assign w_push = in_valid && (!w_full || w_pop);
  assign w_drop = in_valid && !w_push;

  // Writeback fields only mean something for a real, non-trapping write.
  assign w_wb_live = !in_excpt && (in_wrenx || in_wrenf);

  always_comb begin
    w_rec        = '0;
    w_rec.seq    = r_seq;
    w_rec.gap    = r_gap_pending;
    w_rec.excpt  = in_excpt;
    w_rec.priv   = in_priv_mode;
    w_rec.hartid = in_hartid;
    w_rec.pc     = in_pc;
    w_rec.inst   = in_inst;
    w_rec.wrenx  = in_wrenx && !in_excpt;
    w_rec.wrenf  = in_wrenf && !in_excpt;
    w_rec.wrdst  = w_wb_live ? in_wrdst  : '0;
    w_rec.wrdata = w_wb_live ? in_wrdata : '0;
    w_rec.cycle  = w_cycle;
  end

`ifdef RETIRE_TRACE_TIMESTAMP_EN
  logic [CYC_W-1:0] r_cycle;

  always_ff @(posedge clock) begin
    if (reset) r_cycle <= '0;
    else       r_cycle <= r_cycle + CYC_W'(1);
  end

  assign w_cycle = r_cycle;
`else
  assign w_cycle = '0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_seq         <= '0;
      r_drop_count  <= '0;
      r_overflow    <= 1'b0;
      r_gap_pending <= 1'b0;
    end else begin
      // Sequence numbers advance on drops too, so the consumer sees the hole.
      if (in_valid) r_seq <= r_seq + SEQ_W'(1);
      if (w_drop) begin
        if (r_drop_count != '1) r_drop_count <= r_drop_count + DROP_W'(1);
        r_overflow    <= 1'b1;
        r_gap_pending <= 1'b1;
      end else if (w_push) begin
        r_gap_pending <= 1'b0;
      end
    end
  end

  retire_trace_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_rec),
    .i_pop   (w_pop),
    .o_data  (out_rec),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  assign out_valid  = !w_empty;
  assign drop_count = r_drop_count;
  assign overflow   = r_overflow;

endmodule
